ccip_c0_rd_arbiter: RTL and testbench
=====================================

// Module: ccip_c0_rd_arbiter
// PURPOSE
//  Shares the single CCI-P c0 Tx read-request channel among NUM_REQ AFU requesters inside the NLB AFU.
//  Round-robin grant, throttled by c0TxAlmFull and per-requester outstanding-read credits.
//  Routes c0 Rx read responses back to their owner by index encoded in mdata.
//  Supports a drain sequence that stops new grants and waits for all outstanding reads to return.
// PARAMETERS
//  NUM_REQ          4    number of requesters (2..8)
//  MAX_OUTSTANDING  64   max in-flight reads per requester (power of 2)
//  ADDR_W           42   cache-line address width
//  TAG_W            13   requester tag bits carried in mdata above the index
// PORTS
//  pClk               in   1                  AFU clock (all logic on this edge)
//  pClk_reset_n       in   1                  asynchronous active-low reset
//  req_valid          in   NUM_REQ            per-requester read request valid
//  req_addr           in   NUM_REQ*ADDR_W     per-requester cache-line address
//  req_tag            in   NUM_REQ*TAG_W      per-requester tag, returned with response
//  req_ready          out  NUM_REQ            one-hot grant; transfer when valid&ready
//  c0_tx_valid        out  1                  c0 Tx read request valid (registered)
//  c0_tx_addr         out  ADDR_W             c0 Tx address
//  c0_tx_mdata        out  16                 {zero-pad, tag, index}
//  c0_tx_almfull      in   1                  c0 Tx almost-full from FIU
//  c0_rx_rsp_valid    in   1                  c0 Rx read response valid
//  c0_rx_rsp_mdata    in   16                 mdata of response
//  rsp_valid          out  NUM_REQ            one-hot routed response strobe
//  rsp_tag            out  TAG_W              tag of routed response
//  drain_req          in   1                  level; request drain
//  drain_done         out  1                  high in DONE state
//  err_underflow      out  1                  sticky: response for requester with zero outstanding
// BEHAVIOUR
//  Reset (async assert, sync deassert outside): all outputs 0; counters 0; rr pointer 0; FSM RUN.
//  Eligibility: req_valid[i] & (cnt[i] != MAX_OUTSTANDING) & ~almfull_q & state==RUN.
//   almfull_q = c0_tx_almfull registered one cycle; no grant in cycle after almfull high.
//  Arbitration: combinational req_ready, at most one bit set; first eligible at/after pointer, wrapping.
//   On grant of i, pointer <= (i+1) mod NUM_REQ; no grant -> pointer holds.
//  Tx: grant registered to c0_tx_* next cycle (latency 1); c0_tx_valid is a 1-cycle pulse per grant.
//   mdata[IDX_W-1:0] = i, mdata[IDX_W+TAG_W-1:IDX_W] = tag, upper bits 0; IDX_W = clog2(NUM_REQ).
//  Rx: response registered; rsp_valid[idx] and rsp_tag valid 1 cycle after c0_rx_rsp_valid.
//   idx >= NUM_REQ: response dropped, err_underflow set.
//  Counters (width clog2(MAX_OUTSTANDING)+1): +1 on grant, -1 on response, unchanged if both same cycle.
//   Response when cnt==0: cnt stays 0, err_underflow set (cleared only by reset).
//  FSM:
//   RUN   -> DRAIN when drain_req=1.
//   DRAIN no grants; -> DONE when all counters 0 and no Tx pending in output register.
//   DONE  drain_done=1; no grants; -> RUN when drain_req=0.
//   drain_req dropped during DRAIN -> RUN immediately.
//  Responses are always accepted/routed in every state; no backpressure on Rx.
// STRUCTURE
//  Package ccip_arb_pkg: IDX_W/CNT_W derivation, t_arb_state enum {RUN,DRAIN,DONE}, mdata field offsets.
//  Sub-module ccip_rr_arb: parameterised NUM_REQ round-robin picker (eligible vector, pointer -> one-hot grant).
//  Top holds counters, FSM, Tx/Rx pipeline registers.
// TESTING
//  1. NUM_REQ=4, all req_valid=1, almfull=0 -> grants 0,1,2,3,0 on consecutive cycles; mdata[1:0] follows.
//  2. Only req 2 valid, issue 64 grants, no responses -> req_ready[2]=0 on 65th; one response idx 2 -> grant resumes next cycle.
//  3. almfull rises cycle N -> grant allowed at N, none at N+1..while high; resumes 1 cycle after it falls.
//  4. Grant and response for req 1 same cycle with cnt=5 -> cnt stays 5; response mdata=0x0009 -> rsp_valid=4'b0010, rsp_tag=2.
//  5. drain_req=1 with 3 outstanding -> no grants, drain_done after 3rd response +1 cycle; drop drain_req -> RUN.
//  6. Response idx 3 with cnt[3]=0 -> err_underflow=1 sticky; async reset mid-traffic -> all outputs 0 at once.

Source files
------------

// File: rtl/ccip_arb_pkg.sv
// Shared definitions for the CCI-P c0 read arbiter: FSM state encoding,
// width helpers and the mdata field layout.
// Latency: n/a (package). Backpressure: n/a.
// Exports: t_arb_state, idx_width(), cnt_width(), mdata_tag_lsb(), MDATA_W.
package ccip_arb_pkg;

  // Arbiter mode: granting, waiting for in-flight reads, or quiesced.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } t_arb_state;

  localparam int MDATA_W       = 16;
  localparam int MDATA_IDX_LSB = 0;

  // Requester index width; never below 1 so a two-requester build still has a bit.
  function automatic int idx_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  // Outstanding counter must hold MAX_OUTSTANDING itself, hence the extra bit.
  function automatic int cnt_width(input int max_outstanding);
    return $clog2(max_outstanding) + 1;
  endfunction

  // Tag sits directly above the requester index inside mdata.
  function automatic int mdata_tag_lsb(input int num_req);
    return MDATA_IDX_LSB + idx_width(num_req);
  endfunction

endpackage

// File: rtl/ccip_rr_arb.sv
// Round-robin picker: first eligible requester at or after the pointer, wrapping.
// Latency: combinational. Backpressure: none; only bits of eligible can be granted.
// Ports: eligible (in, per requester), ptr (in, search start), grant (out, one-hot),
//        grant_idx (out, encoded grant), grant_any (out, any bit of grant set).
module ccip_rr_arb
  import ccip_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W-1:0] sel;

  // Walk the ring backwards from the farthest slot so the last hit written is
  // the closest eligible slot to ptr; this keeps the loop free of a found flag.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    sel       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sel = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (eligible[sel]) begin
        grant      = '0;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end

  assign grant_any = |grant;

endmodule

// File: rtl/ccip_c0_rd_arbiter.sv
// Shares the CCI-P c0 Tx read channel among NUM_REQ requesters and routes c0 Rx responses back by mdata index.
// Latency: grant -> c0_tx_* 1 cycle; c0_rx -> rsp_* 1 cycle.
// Backpressure: grants withheld while almfull (registered), a requester's credits are exhausted, or draining; Rx never stalls.
// Ports: pClk/pClk_reset_n clock and async active-low reset; req_valid/req_addr/req_tag/req_ready requester side;
//        c0_tx_valid/c0_tx_addr/c0_tx_mdata/c0_tx_almfull FIU Tx side; c0_rx_rsp_valid/c0_rx_rsp_mdata FIU Rx side;
//        rsp_valid/rsp_tag routed response; drain_req/drain_done drain handshake; err_underflow sticky error.
module ccip_c0_rd_arbiter
  import ccip_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 64,
  parameter int ADDR_W          = 42,
  parameter int TAG_W           = 13
) (
  input  logic                      pClk,
  input  logic                      pClk_reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      c0_tx_valid,
  output logic [ADDR_W-1:0]         c0_tx_addr,
  output logic [15:0]               c0_tx_mdata,
  input  logic                      c0_tx_almfull,
  input  logic                      c0_rx_rsp_valid,
  input  logic [15:0]               c0_rx_rsp_mdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [TAG_W-1:0]          rsp_tag,
  input  logic                      drain_req,
  output logic                      drain_done,
  output logic                      err_underflow
);

  localparam int IDX_W   = idx_width(NUM_REQ);
  localparam int CNT_W   = cnt_width(MAX_OUTSTANDING);
  localparam int TAG_LSB = mdata_tag_lsb(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

  t_arb_state          state_q, state_d;
  logic                almfull_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [CNT_W-1:0]    cnt_q [NUM_REQ];

  logic [NUM_REQ-1:0]  cnt_room;
  logic [NUM_REQ-1:0]  cnt_zero;
  logic                run_ok;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_any;

  logic [ADDR_W-1:0]   tx_addr_d;
  logic [TAG_W-1:0]    tx_tag_d;
  logic [15:0]         tx_mdata_d;

  logic [IDX_W-1:0]    rx_idx;
  logic [TAG_W-1:0]    rx_tag;
  logic [NUM_REQ-1:0]  rx_hit;
  logic                rx_underflow;
  logic                rx_mdata_unused;

  // ---------------- eligibility and arbitration ----------------
  always_comb begin
    cnt_room = '0;
    cnt_zero = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_room[i] = (cnt_q[i] != CNT_FULL);
      cnt_zero[i] = (cnt_q[i] == '0);
    end
  end

  // Reset is folded in so req_ready drops the moment reset asserts.
  assign run_ok   = pClk_reset_n & ~almfull_q & (state_q == RUN);
  assign eligible = req_valid & cnt_room & {NUM_REQ{run_ok}};

  ccip_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arb (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;

  // ---------------- Tx request formation ----------------
  always_comb begin
    tx_addr_d = '0;
    tx_tag_d  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        tx_addr_d = req_addr[i*ADDR_W +: ADDR_W];
        tx_tag_d  = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  always_comb begin
    tx_mdata_d                          = '0;
    tx_mdata_d[MDATA_IDX_LSB +: IDX_W]  = grant_idx;
    tx_mdata_d[TAG_LSB +: TAG_W]        = tx_tag_d;
  end

  // ---------------- Rx response decode ----------------
  assign rx_idx          = c0_rx_rsp_mdata[MDATA_IDX_LSB +: IDX_W];
  assign rx_tag          = c0_rx_rsp_mdata[TAG_LSB +: TAG_W];
  assign rx_mdata_unused = ^c0_rx_rsp_mdata[MDATA_W-1:TAG_LSB+TAG_W];

  always_comb begin
    rx_hit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rx_hit[i] = c0_rx_rsp_valid && (rx_idx == IDX_W'(i));
    end
  end

  // A response that decodes to no requester, or to one with nothing in flight,
  // cannot be matched to a request.
  assign rx_underflow = c0_rx_rsp_valid & ((rx_hit == '0) | (|(rx_hit & cnt_zero)));

  // ---------------- drain FSM ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (drain_req) state_d = DRAIN;
      end
      DRAIN: begin
        // A grant from the last RUN cycle may still sit in the Tx register.
        if (!drain_req)                    state_d = RUN;
        else if (&cnt_zero && !c0_tx_valid) state_d = DONE;
      end
      DONE: begin
        if (!drain_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign drain_done = (state_q == DONE);

  // ---------------- sequential state ----------------
  always_ff @(posedge pClk or negedge pClk_reset_n) begin
    if (!pClk_reset_n) begin
      state_q   <= RUN;
      almfull_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      almfull_q <= c0_tx_almfull;
      if (grant_any) ptr_q <= IDX_W'((int'(grant_idx) + 1) % NUM_REQ);
    end
  end

  // Same-cycle grant and response cancel; a response never takes a counter below 0.
  always_ff @(posedge pClk or negedge pClk_reset_n) begin
    if (!pClk_reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && !rx_hit[i])                    cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (!grant[i] && rx_hit[i] && !cnt_zero[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge pClk or negedge pClk_reset_n) begin
    if (!pClk_reset_n) begin
      c0_tx_valid <= 1'b0;
      c0_tx_addr  <= '0;
      c0_tx_mdata <= '0;
    end else begin
      c0_tx_valid <= grant_any;
      if (grant_any) begin
        c0_tx_addr  <= tx_addr_d;
        c0_tx_mdata <= tx_mdata_d;
      end
    end
  end

  always_ff @(posedge pClk or negedge pClk_reset_n) begin
    if (!pClk_reset_n) begin
      rsp_valid     <= '0;
      rsp_tag       <= '0;
      err_underflow <= 1'b0;
    end else begin
      rsp_valid <= rx_hit;
      if (|rx_hit) rsp_tag <= rx_tag;
      if (rx_underflow) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ccip_c0_rd_arbiter.sv
// Directed bench for ccip_c0_rd_arbiter with hand-computed expectations.
// Inputs change just after the falling edge; outputs are sampled 1ns later.
// Requester i drives address 0x100+i and tag 0x10+i, so its mdata is 0x40+5*i.
module tb_ccip_c0_rd_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 42;
  localparam int TAG_W   = 13;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      c0_tx_valid;
  logic [ADDR_W-1:0]         c0_tx_addr;
  logic [15:0]               c0_tx_mdata;
  logic                      c0_tx_almfull;
  logic                      c0_rx_rsp_valid;
  logic [15:0]               c0_rx_rsp_mdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [TAG_W-1:0]          rsp_tag;
  logic                      drain_req;
  logic                      drain_done;
  logic                      err_underflow;

  int n_assert = 0;
  int n_fail   = 0;
  int grants;

  always #5 clk = ~clk;

  ccip_c0_rd_arbiter #(
    .NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(64), .ADDR_W(ADDR_W), .TAG_W(TAG_W)
  ) dut (
    .pClk            (clk),
    .pClk_reset_n    (rst_n),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_tag         (req_tag),
    .req_ready       (req_ready),
    .c0_tx_valid     (c0_tx_valid),
    .c0_tx_addr      (c0_tx_addr),
    .c0_tx_mdata     (c0_tx_mdata),
    .c0_tx_almfull   (c0_tx_almfull),
    .c0_rx_rsp_valid (c0_rx_rsp_valid),
    .c0_rx_rsp_mdata (c0_rx_rsp_mdata),
    .rsp_valid       (rsp_valid),
    .rsp_tag         (rsp_tag),
    .drain_req       (drain_req),
    .drain_done      (drain_done),
    .err_underflow   (err_underflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; one response cycle, then checks its routing.
  task automatic send_rsp(input int idx, input int tag, input string nm);
    c0_rx_rsp_valid = 1'b1;
    c0_rx_rsp_mdata = 16'((tag << 2) | idx);
    @(negedge clk);
    c0_rx_rsp_valid = 1'b0;
    #1;
    chk({nm, "_vld"}, 64'(rsp_valid), 64'(1) << idx);
    chk({nm, "_tag"}, 64'(rsp_tag), 64'(tag));
  endtask

  // Back-to-back responses for one requester.
  task automatic rsp_burst(input int idx, input int n);
    c0_rx_rsp_valid = 1'b1;
    c0_rx_rsp_mdata = 16'(idx);
    repeat (n) @(negedge clk);
    c0_rx_rsp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b1;
    req_valid       = '0;
    c0_tx_almfull   = 1'b0;
    c0_rx_rsp_valid = 1'b0;
    c0_rx_rsp_mdata = '0;
    drain_req       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(42'h100 + i);
      req_tag[i*TAG_W +: TAG_W]    = TAG_W'(13'h10 + i);
    end
    #1 rst_n = 1'b0;
    #2;
    // ---- reset state ----
    chk("rst_tx_valid", 64'(c0_tx_valid), 64'(0));
    chk("rst_tx_mdata", 64'(c0_tx_mdata), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_drain_done", 64'(drain_done), 64'(0));
    chk("rst_err", 64'(err_underflow), 64'(0));
    req_valid = 4'hF;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // ---- 1: all requesting -> 0,1,2,3,0 ----
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t1_grant", 64'(req_ready), 64'(1) << (k % 4));
      @(negedge clk);
      chk("t1_tx_valid", 64'(c0_tx_valid), 64'(1));
      chk("t1_tx_mdata", 64'(c0_tx_mdata), 64'(16'h40 + 5 * (k % 4)));
      chk("t1_tx_addr", 64'(c0_tx_addr), 64'(42'h100 + (k % 4)));
    end
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("t1_tx_pulse", 64'(c0_tx_valid), 64'(0));
    send_rsp(0, 16'h10, "t1_rsp0a");
    send_rsp(0, 16'h10, "t1_rsp0b");
    send_rsp(1, 16'h11, "t1_rsp1");
    send_rsp(2, 16'h12, "t1_rsp2");
    send_rsp(3, 16'h13, "t1_rsp3");
    chk("t1_no_err", 64'(err_underflow), 64'(0));

    // ---- 2: credit exhaustion on requester 2 ----
    req_valid = 4'b0100;
    for (int k = 0; k < 64; k++) begin
      #1;
      chk("t2_grant", 64'(req_ready), 64'(4'b0100));
      @(negedge clk);
    end
    #1;
    chk("t2_full", 64'(req_ready), 64'(0));
    chk("t2_last_tx", 64'(c0_tx_valid), 64'(1));
    @(negedge clk);
    c0_rx_rsp_valid = 1'b1;
    c0_rx_rsp_mdata = 16'h0016;
    #1;
    chk("t2_rsp_cycle", 64'(req_ready), 64'(0));
    @(negedge clk);
    c0_rx_rsp_valid = 1'b0;
    #1;
    chk("t2_resume", 64'(req_ready), 64'(4'b0100));
    chk("t2_rsp_vld", 64'(rsp_valid), 64'(4'b0100));
    chk("t2_rsp_tag", 64'(rsp_tag), 64'(5));
    req_valid = '0;
    rsp_burst(2, 63);
    @(negedge clk);
    chk("t2_no_err", 64'(err_underflow), 64'(0));

    // ---- 4: grant and response for requester 1 in the same cycle at count 5 ----
    req_valid = 4'b0010;
    grants = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      #1;
      if (cyc == 5) begin
        c0_rx_rsp_valid = 1'b1;
        c0_rx_rsp_mdata = 16'h0009;
      end
      if (req_ready == 4'b0010) grants++;
      @(negedge clk);
      if (cyc == 5) begin
        c0_rx_rsp_valid = 1'b0;
        chk("t4_rsp_vld", 64'(rsp_valid), 64'(4'b0010));
        chk("t4_rsp_tag", 64'(rsp_tag), 64'(2));
      end
    end
    chk("t4_total_grants", 64'(grants), 64'(65));
    req_valid = '0;
    rsp_burst(1, 64);
    @(negedge clk);
    chk("t4_no_err", 64'(err_underflow), 64'(0));

    // ---- 3: almfull throttling (pointer now at 2) ----
    req_valid     = 4'hF;
    c0_tx_almfull = 1'b1;
    #1;
    chk("t3_grant_at_rise", 64'(req_ready), 64'(4'b0100));
    @(negedge clk);
    #1;
    chk("t3_blocked1", 64'(req_ready), 64'(0));
    chk("t3_tx_mdata", 64'(c0_tx_mdata), 64'(16'h4A));
    @(negedge clk);
    #1;
    chk("t3_blocked2", 64'(req_ready), 64'(0));
    chk("t3_tx_idle", 64'(c0_tx_valid), 64'(0));
    c0_tx_almfull = 1'b0;
    #1;
    chk("t3_fall_cycle", 64'(req_ready), 64'(0));
    @(negedge clk);
    #1;
    chk("t3_resume", 64'(req_ready), 64'(4'b1000));
    req_valid = '0;
    @(negedge clk);
    send_rsp(2, 16'h12, "t3_rsp2");

    // ---- 5: drain with three reads outstanding (pointer at 3) ----
    req_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_grant", 64'(req_ready), 64'(1) << ((k + 3) % 4));
      @(negedge clk);
    end
    req_valid = '0;
    drain_req = 1'b1;
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    chk("t5_no_grant", 64'(req_ready), 64'(0));
    chk("t5_not_done", 64'(drain_done), 64'(0));
    @(negedge clk);
    #1;
    chk("t5_no_grant2", 64'(req_ready), 64'(0));
    send_rsp(3, 16'h13, "t5_rsp3");
    send_rsp(0, 16'h10, "t5_rsp0");
    chk("t5_not_done2", 64'(drain_done), 64'(0));
    c0_rx_rsp_valid = 1'b1;
    c0_rx_rsp_mdata = 16'h0045;
    @(negedge clk);
    c0_rx_rsp_valid = 1'b0;
    #1;
    chk("t5_done_early", 64'(drain_done), 64'(0));
    @(negedge clk);
    #1;
    chk("t5_done", 64'(drain_done), 64'(1));
    chk("t5_done_no_grant", 64'(req_ready), 64'(0));
    drain_req = 1'b0;
    #1;
    chk("t5_still_done", 64'(req_ready), 64'(0));
    @(negedge clk);
    #1;
    chk("t5_back_run", 64'(drain_done), 64'(0));
    chk("t5_run_grant", 64'(req_ready), 64'(4'b0100));
    req_valid = '0;

    // ---- 6: underflow is sticky; async reset clears everything ----
    @(negedge clk);
    c0_rx_rsp_valid = 1'b1;
    c0_rx_rsp_mdata = 16'h0003;
    @(negedge clk);
    c0_rx_rsp_valid = 1'b0;
    #1;
    chk("t6_err", 64'(err_underflow), 64'(1));
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", 64'(err_underflow), 64'(1));
    req_valid = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("t6_traffic", 64'(c0_tx_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", 64'(req_ready), 64'(0));
    chk("t6_rst_tx_valid", 64'(c0_tx_valid), 64'(0));
    chk("t6_rst_tx_addr", 64'(c0_tx_addr), 64'(0));
    chk("t6_rst_tx_mdata", 64'(c0_tx_mdata), 64'(0));
    chk("t6_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("t6_rst_rsp_tag", 64'(rsp_tag), 64'(0));
    chk("t6_rst_done", 64'(drain_done), 64'(0));
    chk("t6_rst_err", 64'(err_underflow), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_ptr_reset", 64'(req_ready), 64'(4'b0001));
    req_valid = '0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
